// File: rtl/comb_sweep_pkg.sv
// Shared types and sizes for the combinational-unit sweep controller.
// Holds the FSM state encoding, vector/index/counter widths and the mismatch-index helper.
package comb_sweep_pkg;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Lowest bit position where the two tables disagree; 0 when they are equal.
  function automatic logic [IDX_W-1:0] first_diff(input logic [NUM_VEC-1:0] a,
                                                  input logic [NUM_VEC-1:0] b);
    logic [NUM_VEC-1:0] d;
    d = a ^ b;
    first_diff = '0;
    for (int i = NUM_VEC - 1; i >= 0; i--) begin
      if (d[i]) first_diff = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/comb_sweep_ctrl_if.sv
// Control/status bundle between a sweep requester (master) and the sweep controller (slave).
// The slave drives abc into the unit under sweep and returns its y plus the captured table.
interface comb_sweep_ctrl_if;
  import comb_sweep_pkg::*;

  logic               start;
  logic               abort;
  logic               y;
  logic [NUM_VEC-1:0] expected;
  logic [IDX_W-1:0]   abc;
  logic [NUM_VEC-1:0] tt;
  logic               busy;
  logic               done;
  logic               match;
  logic [IDX_W-1:0]   err_idx;

  modport master (
    output start, abort, y, expected,
    input  abc, tt, busy, done, match, err_idx
  );

  modport slave (
    input  start, abort, y, expected,
    output abc, tt, busy, done, match, err_idx
  );

endinterface

// File: rtl/sweep_settle_cnt.sv
// Settle-time counter: held at zero while clr, counts while en; hit when count reaches SETTLE_CYC-1.
// hit is decoded from the registered count, so it rises in the SETTLE_CYC-th cycle after clearing.
module sweep_settle_cnt
  import comb_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = (count == CNT_W'(SETTLE_CYC - 1));

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Walks abc through 0..7, holding each SETTLE_CYC cycles then sampling y into tt; done pulses 8*(SETTLE_CYC+1)+1 cycles after start.
// start is ignored while busy or done; abort clears the sweep. SWEEP_SELFCHECK_EN adds the tt-vs-expected check.
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  comb_sweep_ctrl_if.slave   bus
);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   abc_q;
  logic [NUM_VEC-1:0] tt_q;
  logic [NUM_VEC-1:0] tt_cap;
  logic               busy_q;
  logic               done_q;
  logic               hit;
  logic               start_ok;
  logic               last_cap;

  sweep_settle_cnt #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_SETTLE),
    .en    (state == ST_SETTLE),
    .hit   (hit)
  );

  assign start_ok = (state == ST_IDLE) && bus.start && !bus.abort;
  assign last_cap = (state == ST_CAPTURE) && !bus.abort && (idx == LAST_IDX);

  // Table as it will look after this cycle's capture.
  always_comb begin
    tt_cap      = tt_q;
    tt_cap[idx] = bus.y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      abc_q  <= '0;
      tt_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state  <= ST_SETTLE;
            idx    <= '0;
            abc_q  <= '0;
            tt_q   <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_SETTLE, ST_CAPTURE: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            idx    <= '0;
            abc_q  <= '0;
            tt_q   <= '0;
            busy_q <= 1'b0;
          end else if (state == ST_SETTLE) begin
            if (hit) state <= ST_CAPTURE;
          end else begin
            tt_q <= tt_cap;
            if (idx == LAST_IDX) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx   <= idx + IDX_W'(1);
              abc_q <= idx + IDX_W'(1);
              state <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          abc_q  <= '0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SWEEP_SELFCHECK_EN
  logic             match_q;
  logic [IDX_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      match_q <= 1'b0;
      err_q   <= '0;
    end else if (last_cap) begin
      match_q <= (tt_cap == bus.expected);
      err_q   <= first_diff(tt_cap, bus.expected);
    end
  end

  assign bus.match   = match_q;
  assign bus.err_idx = err_q;
`else
  assign bus.match   = 1'b0;
  assign bus.err_idx = '0;
`endif

  assign bus.abc  = abc_q;
  assign bus.tt   = tt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/comb_sweep_ctrl.md
COMB_SWEEP_CTRL -- requirements
Module: comb_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, giving the number of cycles ABC is held before Y is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a sweep.
REQ-005 The block SHALL have port abort, input, 1 bit: terminates a sweep in progress.
REQ-006 The block SHALL have port y, input, 1 bit: output of the combinational unit under sweep.
REQ-007 The block SHALL have port expected, input, 8 bits: reference truth table, where bit i is Y for {A,B,C}=i.
REQ-008 The block SHALL have port abc, output, 3 bits: drives {A,B,C} of the unit, with A as MSB.
REQ-009 The block SHALL have port tt, output, 8 bits: captured truth table, where bit i is y sampled for abc=i.
REQ-010 The block SHALL have ports busy and done, output, 1 bit each: busy = sweep in progress; done = one-cycle completion pulse.
REQ-011 The block SHALL have ports match (1 bit) and err_idx (3 bits), outputs: self-check result.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SETTLE, CAPTURE and DONE.
REQ-013 In IDLE, start=1 SHALL cause: idx<=0, abc<=3'b000, tt<=0, settle count<=0, next state SETTLE.
REQ-014 In SETTLE, the block SHALL increment the settle count each cycle and move to CAPTURE when count==SETTLE_CYC-1.
REQ-015 In CAPTURE, the block SHALL set tt[idx]<=y and then:
- if idx<7: idx<=idx+1, abc<=idx+1, count<=0, next state SETTLE;
- if idx==7: next state DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1 and SHALL return to IDLE with abc<=0.
REQ-017 busy SHALL be 1 exactly in SETTLE and CAPTURE.
REQ-018 From the start-sampling edge to the done=1 cycle, the latency SHALL be 8*(SETTLE_CYC+1)+1 cycles (25 with the default).
REQ-019 start SHALL be ignored while busy=1 or done=1.
REQ-020 abort=1 in SETTLE or CAPTURE SHALL force IDLE on the next edge with abc<=0 and tt<=0, and SHALL NOT produce a done pulse.
REQ-021 abort and start asserted together in IDLE SHALL leave the block in IDLE (abort wins).
REQ-022 tt SHALL hold its value from DONE until the next accepted start or an abort.
REQ-023 abc SHALL wrap only by returning to 0 through DONE/IDLE; it SHALL never increment past 7.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force: state IDLE, idx=0, count=0, abc=0, tt=0, busy=0, done=0, match=0, err_idx=0. This applies in any state, including mid-sweep.
REQ-025 Reset SHALL take priority over start and abort.

Configuration
REQ-026 With macro SWEEP_SELFCHECK_EN defined:
- on entry to DONE, match SHALL be set to (final tt == expected);
- err_idx SHALL be set to the lowest index i where tt[i]!=expected[i], or 0 if none;
- both SHALL be held until the next accepted start, which clears them.
REQ-027 Without SWEEP_SELFCHECK_EN:
- match and err_idx SHALL be constant 0;
- the expected input SHALL be unused;
- no comparison logic SHALL be synthesized.

Structure
REQ-028 Package comb_sweep_pkg SHALL hold the FSM state typedef, NUM_VEC=8, IDX_W=3 and CNT_W=4.
REQ-029 The settle counter SHALL be the sub-module sweep_settle_cnt (inputs clr, en; output hit when count==SETTLE_CYC-1).

Verification
REQ-030 Default parameter, y driven from the model y=A&B|C, a start pulse -> done 25 cycles later, tt=8'hEA, abc observed as 0..7 in order with each value held 3 cycles.
REQ-031 With SWEEP_SELFCHECK_EN, expected=8'hEA -> match=1, err_idx=0; expected=8'hE8 -> match=0, err_idx=1.
REQ-032 abort raised in the 10th cycle of a sweep -> IDLE next cycle, abc=0, tt=0, no done pulse; a following start produces a full sweep.
REQ-033 start re-pulsed while busy, and start+abort together in IDLE -> both are ignored, and the sweep timing is unchanged.
REQ-034 rst_n=0 mid-sweep with abc=5 -> all outputs 0 on the next edge; then SETTLE_CYC=1 -> done 17 cycles after start.
